peri_uart_tx: RTL

//  Peripheral-bus responder: memory-mapped UART transmitter on the CPU data-memory peripheral bus.
//  The CPU (bus initiator) writes bytes and config; the block serialises them 8N1 on tx and raises irq.

---
 rtl/peri_pkg.sv | 33 +++
 rtl/peri_sync_fifo.sv | 50 +++++
 rtl/peri_uart_tx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/peri_pkg.sv
// Shared register map, bit indices and types for the peripheral-bus UART transmitter.
package peri_pkg;

    localparam logic [1:0] PERI_DATA   = 2'd0;
    localparam logic [1:0] PERI_STATUS = 2'd1;
    localparam logic [1:0] PERI_BAUD   = 2'd2;
    localparam logic [1:0] PERI_CTRL   = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    localparam int CTRL_TX_EN  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_ODD    = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [15:0] wdata;
    } peri_req_t;

endpackage

// File: rtl/peri_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; a pop on a full FIFO frees room for a same-cycle push.
module peri_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_bar,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr, rd_ptr;
    logic                        do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge CLOCK_50) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_ff @(posedge CLOCK_50 or negedge reset_bar) begin
        if (!reset_bar) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/peri_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the peripheral bus.
// Define PERI_UART_PARITY_EN to add a parity bit (even, or odd when CTRL[2]=1).
module peri_uart_tx
    import peri_pkg::*;
#(
    parameter int          FIFO_DEPTH       = 4,
    parameter logic [15:0] DEFAULT_BAUD_DIV = 16'd433
) (
    input  logic        CLOCK_50,
    input  logic        reset_bar,
    input  logic        bus_clk_en,
    input  logic [1:0]  bus_addr,
    input  logic [15:0] bus_wdata,
    input  logic        bus_we,
    input  logic        bus_re,
    output logic [15:0] bus_rdata,
    output logic        bus_ack,
    output logic        irq,
    output logic        tx
);

`ifdef PERI_UART_PARITY_EN
    localparam bit         PAR_EN     = 1'b1;
    localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
    localparam bit         PAR_EN     = 1'b0;
    localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    peri_req_t   req;
    logic        accept, wr, rd;
    logic [15:0] baud;
    logic [2:0]  ctrl;
    logic        ovf, ovf_set, ovf_clr;
    logic        push, pop, full, empty;
    logic [7:0]  fifo_dout;
    logic [CW-1:0] count;
    logic [15:0] status, rd_mux;

    uart_state_t state;
    logic [15:0] cnt;
    logic [2:0]  bitcnt;
    logic [7:0]  shreg;
    logic        par_bit, bit_end, go;

    assign req    = {bus_we, bus_re, bus_addr, bus_wdata};
    assign accept = bus_clk_en & (req.we | req.re);
    assign wr     = accept & req.we;
    assign rd     = accept & req.re & ~req.we;

    assign push    = wr & (req.addr == PERI_DATA);
    assign ovf_set = push & full & ~pop;
    assign ovf_clr = wr & (req.addr == PERI_STATUS) & req.wdata[ST_OVF];

    assign bit_end = (cnt == 16'd0);
    assign go      = ctrl[CTRL_TX_EN] & ~empty;
    // Loading a new frame happens from IDLE or at the last edge of STOP.
    assign pop     = go & ((state == IDLE) | ((state == STOP) & bit_end));

    peri_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLOCK_50  (CLOCK_50),
        .reset_bar (reset_bar),
        .push      (push),
        .pop       (pop),
        .din       (req.wdata[7:0]),
        .dout      (fifo_dout),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        status           = '0;
        status[ST_BUSY]  = (state != IDLE);
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF]   = ovf;
        status[7:4]      = 4'(count);
        case (req.addr)
            PERI_STATUS: rd_mux = status;
            PERI_BAUD:   rd_mux = baud;
            PERI_CTRL:   rd_mux = {13'd0, ctrl};
            default:     rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_bar) begin
        if (!reset_bar) begin
            baud      <= DEFAULT_BAUD_DIV;
            ctrl      <= '0;
            ovf       <= 1'b0;
            bus_ack   <= 1'b0;
            bus_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            bus_ack <= accept;
            if (rd) bus_rdata <= rd_mux;
            if (wr && req.addr == PERI_BAUD) baud <= req.wdata;
            if (wr && req.addr == PERI_CTRL) ctrl <= req.wdata[2:0] & CTRL_WMASK;
            // A drop in the same cycle as a clear keeps the flag set.
            ovf <= (ovf & ~ovf_clr) | ovf_set;
            irq <= ctrl[CTRL_IRQ_EN] & empty & (state == IDLE);
        end
    end

    // cnt reloads from BAUD at every bit boundary, so BAUD edits land on the next bit.
    always_ff @(posedge CLOCK_50 or negedge reset_bar) begin
        if (!reset_bar) begin
            state   <= IDLE;
            cnt     <= '0;
            bitcnt  <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else if (pop) begin
            state   <= START;
            tx      <= 1'b0;
            cnt     <= baud;
            shreg   <= fifo_dout;
            par_bit <= (^fifo_dout) ^ ctrl[CTRL_ODD];
        end else if (state != IDLE) begin
            if (!bit_end) begin
                cnt <= cnt - 1'b1;
            end else begin
                cnt <= baud;
                case (state)
                    START: begin
                        state  <= DATA;
                        bitcnt <= '0;
                        tx     <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                    DATA: begin
                        if (bitcnt == 3'd7) begin
                            if (PAR_EN) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            tx     <= shreg[0];
                            shreg  <= shreg >> 1;
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
